// File: rtl/cmp_share_arbiter.sv
// ---------------------------------------------------------------------------
// cmp_share_arbiter
//
// Round-robin scheduler that shares one magnitude-compare datapath among
// NUM_REQ requesters. One request is accepted in IDLE, compared in CMP
// (one cycle), and the tagged EQ/GT/LT result is offered in RESP until the
// consumer takes it. This gives at most one compare every three cycles.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. On the request side, req_ready is one-hot or zero and is only
// raised in IDLE. A requester holds req_valid and its operands stable until
// it sees its req_ready. On the response side, rsp_valid, rsp_id and the
// flags stay stable while rsp_ready is 0.
//
// Optional build macro: CMP_SHARE_SIGNED_EN
//   When defined, the block adds a cmp_signed input. It is sampled with the
//   operands and selects a two's-complement compare. When undefined, all
//   compares are unsigned.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_ready  out  [NUM_REQ]        per-requester accept (one-hot or zero)
//   req_a      in   [NUM_REQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NUM_REQ*WIDTH]  operand b, same packing
//   cmp_signed in   1                signed compare select (macro builds only)
//   rsp_valid  out  1                response valid
//   rsp_ready  in   1                response consumer ready
//   rsp_id     out  [ID_W]           index of the requester owning the response
//   rsp_eq     out  1                a == b
//   rsp_gt     out  1                a > b
//   rsp_lt     out  1                a < b
//   busy       out  1                high in any state other than IDLE
// ---------------------------------------------------------------------------
module cmp_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef CMP_SHARE_SIGNED_EN
   input  logic                     cmp_signed,
`endif
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_eq,
   output logic                     rsp_gt,
   output logic                     rsp_lt,
   output logic                     busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMP  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Starting from the highest index makes requester 0 the first winner.
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

   logic [1:0]       state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [ID_W-1:0]  id_q;
   logic [ID_W-1:0]  last_grant_q;
`ifdef CMP_SHARE_SIGNED_EN
   logic             signed_q;
`endif

   // Round-robin pick. Candidates above last_grant win over candidates at or
   // below it, and the lowest index wins within each group. This gives the
   // same order as scanning last_grant+1, last_grant+2, ... with wrap. Both
   // scans run downward so the last match is the lowest index.
   logic            hi_found;
   logic            lo_found;
   logic [ID_W-1:0] hi_idx;
   logic [ID_W-1:0] lo_idx;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;

   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (ID_W'(i) > last_grant_q) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = ID_W'(i);
            end
         end
      end
      grant_found = (state_q == IDLE) && (hi_found || lo_found);
      grant_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Ready decode and operand mux. Constant indices keep the mux regular.
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            req_ready[i] = grant_found;
            sel_a        = req_a[i*WIDTH +: WIDTH];
            sel_b        = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Shared comparator. GT is derived so exactly one flag is set.
   logic cmp_eq;
   logic cmp_lt;
   logic cmp_gt;

   assign cmp_eq = (op_a_q == op_b_q);
`ifdef CMP_SHARE_SIGNED_EN
   assign cmp_lt = signed_q ? ($signed(op_a_q) < $signed(op_b_q))
                            : (op_a_q < op_b_q);
`else
   assign cmp_lt = (op_a_q < op_b_q);
`endif
   assign cmp_gt = !cmp_eq && !cmp_lt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         id_q         <= '0;
         last_grant_q <= LAST_RST;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_eq       <= 1'b0;
         rsp_gt       <= 1'b0;
         rsp_lt       <= 1'b0;
`ifdef CMP_SHARE_SIGNED_EN
         signed_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  op_a_q       <= sel_a;
                  op_b_q       <= sel_b;
                  id_q         <= grant_idx;
                  last_grant_q <= grant_idx;
`ifdef CMP_SHARE_SIGNED_EN
                  signed_q     <= cmp_signed;
`endif
                  state_q      <= CMP;
               end
            end
            CMP: begin
               rsp_eq    <= cmp_eq;
               rsp_gt    <= cmp_gt;
               rsp_lt    <= cmp_lt;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmp_share_arbiter
//
// Directed bench for cmp_share_arbiter (NUM_REQ=4, WIDTH=4, ID_W=2).
// Expected grants, ids and flags are hand-computed constants. Response ids
// flow through an expected queue. Builds with or without
// CMP_SHARE_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_cmp_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 4;
   localparam int ID_W    = 2;
   localparam int W       = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #60000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- DUT ----------------
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic                     rsp_eq;
   logic                     rsp_gt;
   logic                     rsp_lt;
   logic                     busy;
`ifdef CMP_SHARE_SIGNED_EN
   logic                     cmp_signed;
`endif

   cmp_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .ID_W    (ID_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
`ifdef CMP_SHARE_SIGNED_EN
      .cmp_signed (cmp_signed),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_eq     (rsp_eq),
      .rsp_gt     (rsp_gt),
      .rsp_lt     (rsp_lt),
      .busy       (busy)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_vec;
   int n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change and outputs are sampled 1-2 time units after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
      req_a = (req_a & ~(16'hF << (4 * idx))) | (16'(a) << (4 * idx));
      req_b = (req_b & ~(16'hF << (4 * idx))) | (16'(b) << (4 * idx));
   endtask

   task automatic apply_reset(input string tag);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      #3;
      check({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rst_busy"},  32'(busy),      32'd0);
      check({tag, "_rst_flags"}, 32'({rsp_eq, rsp_gt, rsp_lt, rsp_id}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // One full transaction. Flags are packed {eq, gt, lt}. When keep is 0,
   // the granted requester drops its valid after acceptance.
   task automatic txn(input string tag, input logic [3:0] vld, input bit keep,
                      input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                      input logic [2:0] exp_flags);
      int cnt;
      logic [W-1:0] want_id;
      req_valid = vld;
      rsp_ready = 1'b1;
      #1;
      cnt = 0;
      while (req_ready == '0 && cnt < 8) begin
         tick();
         cnt++;
      end
      check({tag, "_grant"}, 32'(req_ready), 32'(exp_rdy));
      exp_q.push_back(W'(exp_id));
      tick();
      if (!keep) req_valid = vld & ~exp_rdy;
      cnt = 0;
      while (!rsp_valid && cnt < 8) begin
         tick();
         cnt++;
      end
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      want_id = exp_q.pop_front();
      check({tag, "_rsp_id"}, 32'(rsp_id), 32'(want_id));
      check({tag, "_flags"}, 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(exp_flags));
      tick();
      check({tag, "_done"}, 32'(rsp_valid), 32'd0);
      req_valid = '0;
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec     = 0;
      n_err     = 0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b1;
`ifdef CMP_SHARE_SIGNED_EN
      cmp_signed = 1'b0;
`endif
      #2;

      // 1: single request, latency and busy
      apply_reset("t1");
      set_ops(0, 4'd9, 4'd3);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      check("t1_ready", 32'(req_ready), 32'h1);
      check("t1_idle_busy", 32'(busy), 32'd0);
      tick();                              // accept edge
      req_valid = '0;
      #1;
      check("t1_cmp_ready", 32'(req_ready), 32'h0);
      check("t1_cmp_valid", 32'(rsp_valid), 32'd0);
      check("t1_cmp_busy",  32'(busy),      32'd1);
      tick();                              // second edge: result visible
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_id",    32'(rsp_id),    32'd0);
      check("t1_flags",     32'({rsp_eq, rsp_gt, rsp_lt}), 32'b010);
      tick();                              // handshake edge
      check("t1_post_valid", 32'(rsp_valid), 32'd0);
      check("t1_post_busy",  32'(busy),      32'd0);

      // 2: all requesters valid continuously, rotation 0,1,2,3,0
      apply_reset("t2");
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 4'd5, 4'd5);
      txn("t2_g0", 4'b1111, 1'b1, 4'b0001, 2'd0, 3'b100);
      txn("t2_g1", 4'b1111, 1'b1, 4'b0010, 2'd1, 3'b100);
      txn("t2_g2", 4'b1111, 1'b1, 4'b0100, 2'd2, 3'b100);
      txn("t2_g3", 4'b1111, 1'b1, 4'b1000, 2'd3, 3'b100);
      txn("t2_g4", 4'b1111, 1'b1, 4'b0001, 2'd0, 3'b100);

      // 3: response back-pressure on requester 2
      set_ops(2, 4'd2, 4'd14);
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      #1;
      check("t3_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0001;                 // another requester waits meanwhile
      tick();
      for (int c = 0; c < 5; c++) begin
         check("t3_hold_valid", 32'(rsp_valid), 32'd1);
         check("t3_hold_id",    32'(rsp_id),    32'd2);
         check("t3_hold_flags", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b001);
         check("t3_hold_ready", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("t3_done_valid", 32'(rsp_valid), 32'd0);
      check("t3_next_ready", 32'(req_ready), 32'h1);   // 3 idle, wraps to 0
      req_valid = '0;
      rsp_ready = 1'b0;
      #1;

      // 4: after last_grant=1, requesters 1 and 3 -> 3 then 1
      apply_reset("t4");
      set_ops(1, 4'd1, 4'd7);
      set_ops(3, 4'd12, 4'd12);
      txn("t4_prime", 4'b0010, 1'b0, 4'b0010, 2'd1, 3'b001);
      txn("t4_first", 4'b1010, 1'b0, 4'b1000, 2'd3, 3'b100);
      txn("t4_second", 4'b0010, 1'b0, 4'b0010, 2'd1, 3'b001);

      // 5: asynchronous reset while a response is pending
      set_ops(1, 4'd15, 4'd0);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      tick();
      req_valid = '0;
      tick();
      check("t5_pre_valid", 32'(rsp_valid), 32'd1);
      check("t5_pre_id",    32'(rsp_id),    32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(rsp_valid), 32'd0);
      check("t5_rst_flags", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'd0);
      check("t5_rst_id",    32'(rsp_id),    32'd0);
      check("t5_rst_busy",  32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      set_ops(0, 4'd3, 4'd3);
      txn("t5_prio", 4'b1111, 1'b0, 4'b0001, 2'd0, 3'b100);

      // 6: unsigned boundaries, plus signed mode when built in
      set_ops(0, 4'b1000, 4'b0001);
      txn("t6_uns_8v1", 4'b0001, 1'b0, 4'b0001, 2'd0, 3'b010);
      set_ops(2, 4'd0, 4'd15);
      txn("t6_uns_0v15", 4'b0100, 1'b0, 4'b0100, 2'd2, 3'b001);
      set_ops(3, 4'd15, 4'd15);
      txn("t6_uns_15v15", 4'b1000, 1'b0, 4'b1000, 2'd3, 3'b100);
`ifdef CMP_SHARE_SIGNED_EN
      cmp_signed = 1'b1;
      txn("t6_sgn_m8v1", 4'b0001, 1'b0, 4'b0001, 2'd0, 3'b001);
      set_ops(1, 4'b1111, 4'b1111);
      txn("t6_sgn_eq", 4'b0010, 1'b0, 4'b0010, 2'd1, 3'b100);
      set_ops(2, 4'b0111, 4'b1001);
      txn("t6_sgn_7vm7", 4'b0100, 1'b0, 4'b0100, 2'd2, 3'b010);
      cmp_signed = 1'b0;
      txn("t6_uns_again", 4'b0001, 1'b0, 4'b0001, 2'd0, 3'b010);
`endif

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
